// File: rtl/keyboard_sequencer.sv
// Keyboard sequencer: debounced manual play or fixed-melody playback feeding the tone generator.
// Latency: raw btn to gate is DEBOUNCE_CYCLES+3 cycles; no backpressure, all outputs are registered levels.
module keyboard_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned NOTE_CYCLES     = 12500000,
    parameter int unsigned GAP_CYCLES      = 2500000,
    parameter int unsigned SEQ_LEN         = 8,
    parameter logic [4*SEQ_LEN-1:0] SEQ_PATTERN = 32'h8421_1248,
    localparam int unsigned STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              btn,
    input  logic [3:0]        sw,
    input  logic              mode,
    output logic [3:0]        note_sel,
    output logic              gate,
    output logic              busy,
    output logic [STEP_W-1:0] step_idx
);

    localparam int unsigned DUR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned DUR_W   = (DUR_MAX > 0) ? $clog2(DUR_MAX + 1) : 1;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_SEQ_NOTE,
        ST_SEQ_GAP
    } state_e;

    logic              btn_meta_q, btn_s_q;
    logic              btn_db_q, btn_db_d, btn_db_prev_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [3:0]        note_sel_q, note_sel_d;
    logic              gate_q, gate_d;
    logic              busy_q, busy_d;
    logic              press;
    logic              step_done;

    function automatic logic [3:0] code_of(input logic [STEP_W-1:0] idx);
        logic [4*SEQ_LEN-1:0] shifted;
        shifted = SEQ_PATTERN >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

    // Isolate the lowest set bit: sw[0] wins.
    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = ~btn_db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press = btn_db_q & ~btn_db_prev_q;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        dur_d     = dur_q;
        step_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dur_d = '0;
                if (!mode && btn_db_q) begin
                    state_d = ST_MANUAL;
                end else if (mode && press) begin
                    state_d = ST_SEQ_NOTE;
                    step_d  = '0;
                end
            end
            ST_MANUAL: begin
                if (!btn_db_q) state_d = ST_IDLE;
            end
            ST_SEQ_NOTE: begin
                if (press) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    dur_d   = '0;
                end else if (dur_q == NOTE_LAST) begin
                    dur_d = '0;
                    if (GAP_CYCLES == 0) step_done = 1'b1;
                    else                 state_d   = ST_SEQ_GAP;
                end else begin
                    dur_d = dur_q + 1'b1;
                end
            end
            ST_SEQ_GAP: begin
                if (press) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    dur_d   = '0;
                end else if (dur_q == GAP_LAST) begin
                    dur_d     = '0;
                    step_done = 1'b1;
                end else begin
                    dur_d = dur_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
                dur_d   = '0;
            end
        endcase

        if (step_done) begin
            if (step_q == STEP_LAST) begin
                state_d = ST_IDLE;
                step_d  = '0;
            end else begin
                state_d = ST_SEQ_NOTE;
                step_d  = step_q + 1'b1;
            end
        end
    end

    // Outputs follow the next state so they change on the same edge as the state.
    always_comb begin
        note_sel_d = note_sel_q;
        gate_d     = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:     note_sel_d = 4'd0;
            ST_MANUAL: begin
                note_sel_d = lowest_one(sw);
                gate_d     = 1'b1;
            end
            ST_SEQ_NOTE: begin
                note_sel_d = code_of(step_d);
                gate_d     = |code_of(step_d);
            end
            default:     note_sel_d = note_sel_q;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q    <= 1'b0;
            btn_s_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= ST_IDLE;
            step_q        <= '0;
            dur_q         <= '0;
            note_sel_q    <= 4'd0;
            gate_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            btn_meta_q    <= btn;
            btn_s_q       <= btn_meta_q;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            step_q        <= step_d;
            dur_q         <= dur_d;
            note_sel_q    <= note_sel_d;
            gate_q        <= gate_d;
            busy_q        <= busy_d;
        end
    end

    assign note_sel = note_sel_q;
    assign gate     = gate_q;
    assign busy     = busy_q;
    assign step_idx = step_q;

endmodule

// File: tb/tb_keyboard_sequencer.sv
// Directed scenarios plus random button/mode/switch traffic, checked against a timeline model.
module tb_keyboard_sequencer;

    localparam int DEB    = 4;
    localparam int NOTE   = 10;
    localparam int GAP    = 3;
    localparam int LEN    = 4;
    localparam int PERIOD = NOTE + GAP;
    localparam logic [15:0] PAT = 16'h1208;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       btn    = 1'b0;
    logic       mode   = 1'b0;
    logic [3:0] sw     = 4'd0;
    logic [3:0] note_sel;
    logic       gate;
    logic       busy;
    logic [1:0] step_idx;

    keyboard_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .NOTE_CYCLES    (NOTE),
        .GAP_CYCLES     (GAP),
        .SEQ_LEN        (LEN),
        .SEQ_PATTERN    (PAT)
    ) dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .btn     (btn),
        .sw      (sw),
        .mode    (mode),
        .note_sel(note_sel),
        .gate    (gate),
        .busy    (busy),
        .step_idx(step_idx)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: sync/debounce as stability counts, player as a timeline (elapsed cycles since start).
    int         m_s1, m_s2, m_db, m_dbp, m_run;
    int         m_st;   // 0 idle, 1 manual, 2 sequence
    int         m_e;
    logic [3:0] m_man;

    function automatic logic [3:0] code_at(input int i);
        logic [15:0] p;
        p = PAT;
        return p[4*i +: 4];
    endfunction

    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
        return 4'd0;
    endfunction

    function automatic int exp_gate();
        if (m_st == 1) return 1;
        if (m_st == 2) return ((m_e % PERIOD) < NOTE && code_at(m_e / PERIOD) != 4'd0) ? 1 : 0;
        return 0;
    endfunction

    function automatic int exp_note();
        if (m_st == 1) return int'(m_man);
        if (m_st == 2) return int'(code_at(m_e / PERIOD));
        return 0;
    endfunction

    function automatic int exp_step();
        return (m_st == 2) ? m_e / PERIOD : 0;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_run = 0;
        m_st = 0; m_e = 0; m_man = 4'd0;
    endtask

    task automatic model_step();
        bit press;
        press = (m_db == 1 && m_dbp == 0);
        case (m_st)
            0: begin
                if (mode == 1'b0 && m_db == 1) begin
                    m_st = 1; m_man = lowest(sw);
                end else if (mode == 1'b1 && press) begin
                    m_st = 2; m_e = 0;
                end
            end
            1: begin
                if (m_db == 0) m_st = 0;
                else           m_man = lowest(sw);
            end
            default: begin
                if (press) m_st = 0;
                else begin
                    m_e++;
                    if (m_e == LEN * PERIOD) m_st = 0;
                end
            end
        endcase
        m_dbp = m_db;
        if (m_s2 != m_db) begin
            if (m_run == DEB - 1) begin
                m_db = 1 - m_db; m_run = 0;
            end else m_run++;
        end else m_run = 0;
        m_s2 = m_s1;
        m_s1 = int'(btn);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        chk("gate",     32'(gate),     exp_gate());
        chk("note_sel", 32'(note_sel), exp_note());
        chk("busy",     32'(busy),     (m_st != 0) ? 1 : 0);
        chk("step_idx", 32'(step_idx), exp_step());
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g, nb, ng, k, hold;

        // Reset state
        model_reset();
        #12;
        check_outputs();
        rst_n = 1'b1;
        repeat (4) tick();

        // Bounce: btn toggles every 2 cycles, then holds high
        g = 0;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            tick(); if (gate) g++;
            tick(); if (gate) g++;
        end
        chk("bounce_gate_low", g, 0);
        btn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!gate && n < 20);
        chk("bounce_to_gate", n, 7);

        // Manual priority
        sw = 4'b0110; tick();
        chk("prio_0110", note_sel, 4'b0010);
        sw = 4'b0100; tick();
        chk("prio_0100", note_sel, 4'b0100);
        sw = 4'b0000; tick();
        chk("sw0_gate", gate, 1);
        chk("sw0_note", note_sel, 0);
        btn = 1'b0;
        n = 0;
        do begin tick(); n++; end while (gate && n < 20);
        chk("release_to_idle", n, 7);
        chk("release_busy", busy, 0);

        // Async reset mid-MANUAL
        btn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!gate && n < 20);
        chk("remanual", n, 7);
        sw = 4'b1000; tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gate", gate, 0);
        chk("arst_note", note_sel, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        #2 rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!gate && n < 20);
        chk("post_reset_manual", n, 7);
        btn = 1'b0;
        repeat (10) tick();

        // Full sequence
        mode = 1'b1; sw = 4'b1111; btn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!busy && n < 20);
        chk("seq_start", n, 7);
        chk("seq_first_note", note_sel, 4'b1000);
        nb = 0; ng = 0; k = 0;
        while (busy && k < 100) begin
            nb++;
            if (gate) ng++;
            if (k == 2) btn = 1'b0;
            tick(); k++;
        end
        chk("seq_busy_len", nb, 52);
        chk("seq_gate_cycles", ng, 30);
        chk("seq_end_step", step_idx, 0);
        repeat (10) tick();

        // Abort during step 2
        btn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!busy && n < 20);
        chk("abort_start", n, 7);
        k = 0;
        while (step_idx != 2'd2 && k < 60) begin
            if (k == 3) btn = 1'b0;
            tick(); k++;
        end
        chk("abort_reach_step2", step_idx, 2);
        btn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (busy && n < 20);
        chk("abort_latency", n, 7);
        chk("abort_gate", gate, 0);
        chk("abort_note", note_sel, 0);
        chk("abort_step", step_idx, 0);
        g = 0;
        repeat (30) begin tick(); if (gate || busy) g++; end
        chk("abort_no_more", g, 0);
        btn = 1'b0;
        repeat (10) tick();

        // Mode toggled mid-sequence
        btn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!busy && n < 20);
        chk("mode_seq_start", n, 7);
        nb = 0; ng = 0; k = 0;
        while (busy && k < 100) begin
            nb++;
            if (gate) ng++;
            if (k == 2) btn = 1'b0;
            if (k == 4) mode = 1'b0;
            tick(); k++;
        end
        chk("mode_busy_len", nb, 52);
        chk("mode_gate_cycles", ng, 30);
        g = 0;
        repeat (20) begin tick(); if (busy) g++; end
        chk("mode_idle_persist", g, 0);

        // Random traffic
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                btn  = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(5, 40));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keyboard_sequencer.md
Name: keyboard_sequencer

Overview:
- Controller that sequences the keyboard tone datapath.
- Drives its note-select lines (sw1..sw4) and play gate (btn) from either the board switches/button (manual) or an internal fixed melody (sequence mode).
- Sits between the raw board inputs and the keyboard tone generator; owns button synchronisation/debounce and arbitration between manual play and sequence playback.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a btn level change (10 ms at 50 MHz)
NOTE_CYCLES, 12500000, cycles gate is held per sequence step (250 ms)
GAP_CYCLES, 2500000, silent cycles between sequence steps (50 ms)
SEQ_LEN, 8, number of steps in the melody (>=1)
SEQ_PATTERN, 32'h8421_1248, SEQ_LEN 4-bit one-hot note codes, step 0 in bits [3:0]; code 0 = rest

Ports:
sysclk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
btn  input  1  raw push button, asynchronous, bouncy
sw  input  4  manual note switches, sw[0] highest priority
mode  input  1  0 = manual, 1 = sequence playback
note_sel  output  4  one-hot note select to tone generator sw1..sw4 (bit 0 -> sw1)
gate  output  1  play enable to tone generator btn
busy  output  1  high while not IDLE
step_idx  output  $clog2(SEQ_LEN) (min 1)  current sequence step

Behaviour:
- Reset (rst_n low, async): state IDLE; note_sel=0, gate=0, busy=0, step_idx=0; sync flops, btn_db and all counters 0. Release is synchronous to sysclk.
- Sync: btn through 2 flops -> btn_s.
- Debounce: counter increments while btn_s != btn_db and clears on any cycle where they are equal. When counter == DEBOUNCE_CYCLES-1 and still differs, btn_db toggles on the next edge and the counter clears.
- Latency: raw btn edge to btn_db change = DEBOUNCE_CYCLES+2 cycles.
- press = one-cycle pulse on btn_db rising.
- Outputs are registered and update on the same edge as the state change: raw btn to gate = DEBOUNCE_CYCLES+3 cycles.
- FSM states and transitions:
  - IDLE: gate=0, note_sel=0.
    - mode=0 and btn_db=1 -> MANUAL.
    - mode=1 and press -> SEQ_NOTE, step_idx=0, duration counter=0.
  - MANUAL: gate=1; note_sel = priority one-hot of sw (lowest set bit), re-evaluated every cycle; sw=0 gives note_sel=0 with gate still 1.
    - btn_db=0 -> IDLE.
    - mode changes are ignored in this state.
  - SEQ_NOTE: note_sel = SEQ_PATTERN code[step_idx]; gate=1 unless code==0 (rest: gate=0).
    - Hold NOTE_CYCLES cycles, then -> SEQ_GAP.
  - SEQ_GAP: gate=0, note_sel unchanged.
    - After GAP_CYCLES cycles: if step_idx==SEQ_LEN-1 -> IDLE with step_idx=0; else step_idx+1 and -> SEQ_NOTE.
    - GAP_CYCLES=0 means go straight to the next note.
- Abort: press in SEQ_NOTE/SEQ_GAP -> IDLE next edge, gate=0, note_sel=0, step_idx=0. The press that started a sequence does not abort it.
- mode is sampled only in IDLE; toggling it during a sequence has no effect until IDLE.
- Duration counters are sized $clog2(max(NOTE_CYCLES,GAP_CYCLES)+1); no wrap is possible.
- Non-one-hot SEQ_PATTERN codes pass through unchanged; the caller is responsible for validity.
- busy = (state != IDLE), registered.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, NOTE_CYCLES=10, GAP_CYCLES=3, SEQ_LEN=4, SEQ_PATTERN=16'h1208 (steps: 1000, 0000, 0010, 0001).
- Reset: rst_n=0 mid-MANUAL with gate=1 -> gate/note_sel/busy drop to 0 without waiting for a clock edge; after release, btn held high re-enters MANUAL only after 7 cycles.
- Bounce: mode=0; btn toggles every 2 cycles for 20 cycles, then holds 1 -> gate stays 0 during the bounce, then rises exactly 7 cycles after the final stable edge.
- Manual priority: btn held, sw=4'b0110 -> note_sel=0010; sw->4'b0100 -> note_sel=0100 next cycle; btn released -> gate=0 7 cycles after release, state IDLE.
- Sequence: mode=1, one clean press. Expected output:
  - note_sel=1000, gate=1 for 10 cycles; then gate=0 for 3.
  - Step 1 (rest): gate=0 for 13 cycles.
  - Step 2: 0010 with gate=1 for 10 cycles.
  - Step 3: 0001 with gate=1 for 10 cycles, then gap.
  - Then busy=0, step_idx=0. Total busy = 52 cycles.
- Abort: second press during step 2 -> gate=0, note_sel=0, step_idx=0 one cycle after btn_db rises; no further notes.
- Mode mid-sequence: mode 1->0 during step 0 -> sequence completes all 4 steps unchanged; with btn low afterwards, IDLE persists.
